seq_detect_scheduler: RTL and testbench

//  Shares one "100" Moore sequence detector between two requesters. Round-robin

---
 rtl/seq_sched_pkg.sv | 19 +
 rtl/seq100_detector.sv | 41 ++++
 rtl/seq_detect_scheduler.sv | 134 +++++++++++++
 tb/tb_seq_detect_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for the "100" detector scheduler.
package seq_sched_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH
  } sched_state_t;

  typedef enum logic [1:0] {
    S0,
    S1,
    S10,
    S100
  } det_state_t;

endpackage

// File: rtl/seq100_detector.sv
// Overlapping Moore detector for the serial pattern "100"; w is high only in S100.
// state | meaning
// S0    | no useful prefix
// S1    | last bit was 1
// S10   | last bits were 1,0
// S100  | pattern just completed
module seq100_detector
  import seq_sched_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic j,
  output logic w
);

  det_state_t state_q, state_d;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S0;
    end else if (en) begin
      unique case (state_q)
        S0:      state_d = j ? S1 : S0;
        S1:      state_d = j ? S1 : S10;
        S10:     state_d = j ? S1 : S100;
        S100:    state_d = j ? S1 : S0;
        default: state_d = S0;
      endcase
    end
    w = (state_q == S100);
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin sharing of one "100" detector between two requesters; each granted
// word is shifted MSB-first through the detector and its hit count is reported.
// state | meaning
// IDLE  | arbitrate, grant latches the word
// SHIFT | one word bit per cycle into the detector
// FLUSH | count a hit produced by the final bit
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int HIT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             busy,
  output logic             bit_out,
  output logic             det,
  output logic             done,
  output logic             done_id,
  output logic [HIT_W-1:0] hits
);

  localparam int CW = $clog2(WIDTH);

  sched_state_t     state_q, state_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [HIT_W-1:0] hitcnt_q, hitcnt_d;
  logic             id_q, id_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic             det_clear, det_en;
  logic [HIT_W-1:0] hit_inc;

  seq100_detector u_det (
    .clock (clock),
    .reset (reset),
    .clear (det_clear),
    .en    (det_en),
    .j     (bit_out),
    .w     (det)
  );

  assign hit_inc = (det && (hitcnt_q != {HIT_W{1'b1}})) ? hitcnt_q + HIT_W'(1) : hitcnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= 1'b1;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      hitcnt_q  <= '0;
      id_q      <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      hits_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      hitcnt_q  <= hitcnt_d;
      id_q      <= id_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      hits_q    <= hits_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    hitcnt_d  = hitcnt_q;
    id_d      = id_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    hits_d    = hits_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    det_clear = 1'b0;
    det_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // rr_q holds the last granted requester; the other one wins a tie.
        if (!reset) begin
          if (req0 && (!req1 || rr_q)) gnt0 = 1'b1;
          else if (req1)               gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) begin
          shreg_d   = gnt1 ? data1 : data0;
          det_clear = 1'b1;
          hitcnt_d  = '0;
          id_d      = gnt1;
          rr_d      = gnt1;
          bitcnt_d  = CW'(WIDTH - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        det_en   = 1'b1;
        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
        hitcnt_d = hit_inc;
        if (bitcnt_q == '0) state_d = FLUSH;
        else                bitcnt_d = bitcnt_q - CW'(1);
      end
      FLUSH: begin
        hitcnt_d  = hit_inc;
        hits_d    = hit_inc;
        done_id_d = id_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == SHIFT) || (state_q == FLUSH);
  assign bit_out = (state_q == SHIFT) && shreg_q[WIDTH-1];
  assign done    = done_q;
  assign done_id = done_id_q;
  assign hits    = hits_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Self-checking bench for seq_detect_scheduler: vector table, scoreboard of
// expected per-word results, and hand sequences for arbitration and mid-word reset.
module tb_seq_detect_scheduler;

  localparam int W  = 8;
  localparam int HW = $clog2(W) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [W-1:0]  data0, data1;
  logic          gnt0, gnt1, busy, bit_out, det, done, done_id;
  logic [HW-1:0] hits;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          id;
    logic [HW-1:0] hits;
  } exp_t;

  typedef struct {
    logic          id;
    logic [W-1:0]  data;
    logic [HW-1:0] hits;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];

  seq_detect_scheduler #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .req0    (req0),
    .data0   (data0),
    .gnt0    (gnt0),
    .req1    (req1),
    .data1   (data1),
    .gnt1    (gnt1),
    .busy    (busy),
    .bit_out (bit_out),
    .det     (det),
    .done    (done),
    .done_id (done_id),
    .hits    (hits)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Number of "100" substrings in the word, MSB first.
  function automatic logic [HW-1:0] count_100(input logic [W-1:0] d);
    int n = 0;
    for (int i = W - 1; i >= 2; i--)
      if (d[i] && !d[i-1] && !d[i-2]) n++;
    return HW'(n);
  endfunction

  always @(negedge clock) begin
    if (gnt0 || gnt1) check("gnt_exclusive", int'(gnt0 & gnt1), 0);
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("done_id", int'(done_id), int'(mon_e.id));
        check("hits", int'(hits), int'(mon_e.hits));
      end
    end
  end

  task automatic send_word(input logic id, input logic [W-1:0] d, input logic [HW-1:0] eh);
    bit got = 0;
    @(posedge clock); #1;
    if (id) begin req1 = 1'b1; data1 = d; end
    else    begin req0 = 1'b1; data0 = d; end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      if (id ? gnt1 : gnt0) begin
        got = 1;
        sb.push_back('{id: id, hits: eh});
      end
    end
    check("grant_seen", int'(got), 1);
    @(posedge clock); #1;
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clock);
    @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w2;
    logic         exp_id;
    logic         gid;
    bit           got;
    bit           saw_done;
    int           n;

    vecs[0] = '{id: 1'b0, data: 8'b1001_0010, hits: 4'd2};
    vecs[1] = '{id: 1'b0, data: 8'b1111_1100, hits: 4'd1};
    vecs[2] = '{id: 1'b0, data: 8'h00,        hits: 4'd0};
    vecs[3] = '{id: 1'b1, data: 8'b1000_0100, hits: 4'd2};
    vecs[4] = '{id: 1'b1, data: 8'b1010_1010, hits: 4'd0};
    vecs[5] = '{id: 1'b0, data: 8'b1001_1001, hits: 4'd2};
    vecs[6] = '{id: 1'b1, data: 8'hFF,        hits: 4'd0};
    vecs[7] = '{id: 1'b0, data: 8'b0100_1001, hits: 4'd2};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;

    // Reset held three cycles.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_gnt0", int'(gnt0), 0);
    check("rst_gnt1", int'(gnt1), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_hits", int'(hits), 0);
    check("rst_det", int'(det), 0);
    check("rst_bit_out", int'(bit_out), 0);
    #1 reset = 1'b0;

    // Single word: serial bit order and grant-to-done latency.
    w2 = 8'b1001_0010;
    send_word(1'b0, w2, 4'd2);
    for (int i = 0; i < W; i++) begin
      @(negedge clock);
      check("shift_busy", int'(busy), 1);
      check("bit_out", int'(bit_out), int'(w2[W-1-i]));
    end
    @(negedge clock);
    check("flush_busy", int'(busy), 1);
    check("flush_bit_out", int'(bit_out), 0);
    check("flush_no_done", int'(done), 0);
    @(negedge clock);
    check("done_latency", int'(done), 1);
    check("idle_busy", int'(busy), 0);
    wait_drain();

    for (int v = 0; v < 8; v++) begin
      send_word(vecs[v].id, vecs[v].data, vecs[v].hits);
      wait_drain();
    end

    // Simultaneous requests: req0 wins, req1 granted in the done cycle.
    do_reset(2);
    @(posedge clock); #1;
    req0 = 1'b1; data0 = 8'b1111_1100;
    req1 = 1'b1; data1 = 8'b1000_0100;
    @(negedge clock);
    check("tie_gnt0", int'(gnt0), 1);
    check("tie_gnt1", int'(gnt1), 0);
    if (gnt0) sb.push_back('{id: 1'b0, hits: 4'd1});
    @(posedge clock); #1 req0 = 1'b0;
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clock);
      if (gnt1) begin
        got = 1;
        check("gnt1_in_done_cycle", int'(done), 1);
        sb.push_back('{id: 1'b1, hits: 4'd2});
      end
    end
    check("gnt1_seen", int'(got), 1);
    @(posedge clock); #1 req1 = 1'b0;
    wait_drain();

    // Reset during the fourth SHIFT cycle discards the word.
    send_word(1'b0, 8'b1001_0010, 4'd2);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    if (sb.size() != 0) void'(sb.pop_back());
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_hits", int'(hits), 0);
    check("rst_mid_done_id", int'(done_id), 0);
    saw_done = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) saw_done = 1;
    end
    check("rst_mid_no_done", int'(saw_done), 0);
    send_word(1'b0, 8'b1001_0010, 4'd2);
    wait_drain();

    // Both requesters held: grants alternate 0,1,0,1.
    do_reset(2);
    @(posedge clock); #1;
    data0 = W'($urandom); data1 = W'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    exp_id = 1'b0;
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge clock);
      if (gnt0 || gnt1) begin
        gid = gnt1;
        check("alt_order", int'(gid), int'(exp_id));
        sb.push_back('{id: gid, hits: count_100(gid ? data1 : data0)});
        exp_id = ~exp_id;
        n++;
        @(posedge clock); #1;
        if (gid) data1 = W'($urandom);
        else     data0 = W'($urandom);
        if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    check("alt_grant_count", n, 4);
    req0 = 1'b0; req1 = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
